// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - sequences train/evaluate epochs over a stored sample set
// and scores an external perceptron until it converges or the epoch budget runs out.
module perceptron_trainer #(
    parameter int INPUT_UNITS = 2,
    parameter int NUM_SAMPLES = 4,
    parameter int EPOCHS      = 10,
    parameter int PRED_LAT    = 1,
    parameter int DATA_W      = 16,
    localparam int AW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int EW   = $clog2(EPOCHS + 1),
    localparam int CNTW = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                load_valid,
    input  logic [AW-1:0]                       load_addr,
    input  logic [INPUT_UNITS-1:0][DATA_W-1:0]  load_values,
    input  logic [DATA_W-1:0]                   load_expected,
    input  logic [DATA_W-1:0]                   learning_rate_in,
    output logic [INPUT_UNITS-1:0][DATA_W-1:0]  values,
    output logic [DATA_W-1:0]                   expected,
    output logic                                training,
    output logic [DATA_W-1:0]                   learning_rate,
    input  logic [DATA_W-1:0]                   prediction,
    output logic                                busy,
    output logic                                done,
    output logic                                converged,
    output logic [EW-1:0]                       epoch,
    output logic [CNTW-1:0]                     correct
);

    localparam int IW = $clog2(NUM_SAMPLES + PRED_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_EVAL, S_DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_SAMPLES-1:0][INPUT_UNITS-1:0][DATA_W-1:0] store_vals_q, store_vals_d;
    logic [NUM_SAMPLES-1:0][DATA_W-1:0] store_exp_q, store_exp_d;
    logic [PRED_LAT-1:0][DATA_W-1:0] exp_pipe_q, exp_pipe_d;
    logic [PRED_LAT-1:0] vld_pipe_q, vld_pipe_d;

    logic [INPUT_UNITS-1:0][DATA_W-1:0] values_q, values_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [DATA_W-1:0] learning_rate_q, learning_rate_d;
    logic training_q, training_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic converged_q, converged_d;
    logic [EW-1:0] epoch_q, epoch_d;
    logic [CNTW-1:0] correct_q, correct_d;

    logic match;
    logic [EW-1:0] epoch_inc;
    logic [CNTW-1:0] correct_inc;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        store_vals_d    = store_vals_q;
        store_exp_d     = store_exp_q;
        learning_rate_d = learning_rate_q;
        converged_d     = converged_q;
        epoch_d         = epoch_q;
        correct_d       = correct_q;
        values_d        = '0;
        expected_d      = '0;

        if (state_q == S_IDLE && load_valid && int'(load_addr) < NUM_SAMPLES) begin
            store_vals_d[load_addr] = load_values;
            store_exp_d[load_addr]  = load_expected;
        end

        // Expected targets travel alongside the perceptron's latency so they line up with prediction.
        exp_pipe_d[0] = expected_q;
        vld_pipe_d[0] = (state_q == S_EVAL) && (idx_q < IW'(NUM_SAMPLES));
        for (int i = 1; i < PRED_LAT; i++) begin
            exp_pipe_d[i] = exp_pipe_q[i-1];
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        match       = vld_pipe_q[PRED_LAT-1] && (prediction == exp_pipe_q[PRED_LAT-1]);
        correct_inc = correct_q + CNTW'(match);
        epoch_inc   = epoch_q + EW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_TRAIN;
                    idx_d           = '0;
                    learning_rate_d = learning_rate_in;
                    epoch_d         = '0;
                    correct_d       = '0;
                    converged_d     = 1'b0;
                end
            end
            S_TRAIN: begin
                if (idx_q == IW'(NUM_SAMPLES - 1)) begin
                    state_d   = S_EVAL;
                    idx_d     = '0;
                    correct_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_EVAL: begin
                correct_d = correct_inc;
                if (idx_q == IW'(NUM_SAMPLES + PRED_LAT - 1)) begin
                    idx_d   = '0;
                    epoch_d = epoch_inc;
                    if (correct_inc == CNTW'(NUM_SAMPLES)) begin
                        converged_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (epoch_inc == EW'(EPOCHS)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TRAIN;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        training_d = (state_d == S_TRAIN);
        busy_d     = (state_d == S_TRAIN) || (state_d == S_EVAL);
        done_d     = (state_d == S_DONE);
        // Outputs are decoded from the next state so they land in the same cycle as the state they describe.
        if (training_d || (state_d == S_EVAL && idx_d < IW'(NUM_SAMPLES))) begin
            values_d   = store_vals_d[idx_d[AW-1:0]];
            expected_d = store_exp_d[idx_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            store_vals_q    <= '0;
            store_exp_q     <= '0;
            exp_pipe_q      <= '0;
            vld_pipe_q      <= '0;
            values_q        <= '0;
            expected_q      <= '0;
            learning_rate_q <= '0;
            training_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            converged_q     <= 1'b0;
            epoch_q         <= '0;
            correct_q       <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            store_vals_q    <= store_vals_d;
            store_exp_q     <= store_exp_d;
            exp_pipe_q      <= exp_pipe_d;
            vld_pipe_q      <= vld_pipe_d;
            values_q        <= values_d;
            expected_q      <= expected_d;
            learning_rate_q <= learning_rate_d;
            training_q      <= training_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            converged_q     <= converged_d;
            epoch_q         <= epoch_d;
            correct_q       <= correct_d;
        end
    end

    assign values        = values_q;
    assign expected      = expected_q;
    assign training      = training_q;
    assign learning_rate = learning_rate_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign converged     = converged_q;
    assign epoch         = epoch_q;
    assign correct       = correct_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - bench for perceptron_trainer at PRED_LAT 1 and 2,
// driving stub predictions from a per-epoch right/wrong plan.
module tb_perceptron_trainer;
    localparam int IU = 2;
    localparam int NS = 4;
    localparam int EP = 10;
    localparam int DW = 16;
    localparam logic [DW-1:0] ONE = 16'h0100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic load_valid = 1'b0;
    logic [1:0] load_addr = '0;
    logic [IU-1:0][DW-1:0] load_values = '0;
    logic [DW-1:0] load_expected = '0;
    logic [DW-1:0] lr_in = '0;

    logic [IU-1:0][DW-1:0] values0, values1;
    logic [DW-1:0] expected0, expected1, lr0, lr1;
    logic [DW-1:0] pred0 = '0, pred1 = '0;
    logic training0, training1, busy0, busy1, done0, done1, conv0, conv1;
    logic [3:0] epoch0, epoch1;
    logic [2:0] correct0, correct1;

    perceptron_trainer #(.INPUT_UNITS(IU), .NUM_SAMPLES(NS), .EPOCHS(EP), .PRED_LAT(1), .DATA_W(DW)) u0 (
        .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_addr(load_addr),
        .load_values(load_values), .load_expected(load_expected), .learning_rate_in(lr_in),
        .values(values0), .expected(expected0), .training(training0), .learning_rate(lr0),
        .prediction(pred0), .busy(busy0), .done(done0), .converged(conv0), .epoch(epoch0), .correct(correct0));

    perceptron_trainer #(.INPUT_UNITS(IU), .NUM_SAMPLES(NS), .EPOCHS(EP), .PRED_LAT(2), .DATA_W(DW)) u1 (
        .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_addr(load_addr),
        .load_values(load_values), .load_expected(load_expected), .learning_rate_in(lr_in),
        .values(values1), .expected(expected1), .training(training1), .learning_rate(lr1),
        .prediction(pred1), .busy(busy1), .done(done1), .converged(conv1), .epoch(epoch1), .correct(correct1));

    always #5 clk = ~clk;

    logic [IU-1:0][DW-1:0] m_vals [NS];
    logic [DW-1:0] m_exp [NS];
    bit ok [EP][NS];
    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int tally(input int e);
        int n = 0;
        for (int k = 0; k < NS; k++) n += ok[e][k] ? 1 : 0;
        return n;
    endfunction

    function automatic int end_epoch();
        for (int e = 0; e < EP; e++) if (tally(e) == NS) return e + 1;
        return EP;
    endfunction

    // conv_e >= EP means the stub never gets a whole epoch right.
    task automatic make_plan(input int conv_e);
        for (int e = 0; e < EP; e++) begin
            for (int k = 0; k < NS; k++) ok[e][k] = bit'($urandom_range(1));
            if (e < conv_e) ok[e][$urandom_range(NS-1)] = 1'b0;
            if (e == conv_e) for (int k = 0; k < NS; k++) ok[e][k] = 1'b1;
        end
    endtask

    task automatic do_load(input int a, input logic [IU-1:0][DW-1:0] v, input logic [DW-1:0] x);
        load_valid = 1'b1; load_addr = 2'(a); load_values = v; load_expected = x;
        @(posedge clk); #1;
        load_valid = 1'b0;
        m_vals[a] = v; m_exp[a] = x;
    endtask

    task automatic load_and();
        for (int k = 0; k < NS; k++)
            do_load(k, {((k & 2) != 0) ? ONE : 16'h0, ((k & 1) != 0) ? ONE : 16'h0}, (k == 3) ? ONE : 16'h0);
    endtask

    task automatic load_xor();
        for (int k = 0; k < NS; k++)
            do_load(k, {((k & 2) != 0) ? ONE : 16'h0, ((k & 1) != 0) ? ONE : 16'h0}, (k == 1 || k == 2) ? ONE : 16'h0);
    endtask

    // Stub perceptron: the result for sample k appears pl cycles after it is shown in EVAL.
    function automatic logic [DW-1:0] pred_for(input int c, input int pl, input int e_end);
        int ep_len = 2 * NS + pl;
        int e = c / ep_len;
        int k = (c % ep_len) - NS - pl;
        if (e < e_end && k >= 0 && k < NS) return ok[e][k] ? m_exp[k] : ~m_exp[k];
        return DW'($urandom);
    endfunction

    task automatic check_unit(input int u, input int c, input int pl, input int e_end, input logic [DW-1:0] lr_exp,
                              input logic [IU-1:0][DW-1:0] v, input logic [DW-1:0] ex, input logic tr,
                              input logic bsy, input logic dn, input logic cv, input logic [3:0] ep,
                              input logic [2:0] cr, input logic [DW-1:0] lr);
        int ep_len = 2 * NS + pl;
        int done_c = e_end * ep_len;
        int p = c % ep_len;
        int e = c / ep_len;
        string t = $sformatf("u%0d c%0d", u, c);
        if (c < done_c) begin
            chk({t, " training"}, tr, (p < NS));
            chk({t, " busy"}, bsy, 1);
            chk({t, " done"}, dn, 0);
            chk({t, " epoch"}, ep, e);
            chk({t, " lr"}, lr, lr_exp);
            if (p < NS) begin
                chk({t, " values"}, v, m_vals[p]);
                chk({t, " expected"}, ex, m_exp[p]);
            end else if (p < 2 * NS) begin
                chk({t, " values"}, v, m_vals[p-NS]);
                chk({t, " expected"}, ex, m_exp[p-NS]);
            end else begin
                chk({t, " flush values"}, v, 0);
                chk({t, " flush expected"}, ex, 0);
            end
            if (p == 0 && e > 0) chk({t, " prev tally"}, cr, tally(e - 1));
            if (p >= NS && p <= NS + pl) chk({t, " eval clear"}, cr, 0);
        end else if (c <= done_c + 1) begin
            chk({t, " done"}, dn, (c == done_c));
            chk({t, " busy"}, bsy, 0);
            chk({t, " training"}, tr, 0);
            chk({t, " values"}, v, 0);
            chk({t, " converged"}, cv, (tally(e_end - 1) == NS));
            chk({t, " epoch"}, ep, e_end);
            chk({t, " correct"}, cr, tally(e_end - 1));
        end
    endtask

    task automatic check_zero(input string t);
        chk({t, " values0"}, values0, 0);   chk({t, " values1"}, values1, 0);
        chk({t, " expected0"}, expected0, 0); chk({t, " expected1"}, expected1, 0);
        chk({t, " flags0"}, {training0, busy0, done0, conv0}, 0);
        chk({t, " flags1"}, {training1, busy1, done1, conv1}, 0);
        chk({t, " counts0"}, {epoch0, correct0, lr0}, 0);
        chk({t, " counts1"}, {epoch1, correct1, lr1}, 0);
    endtask

    // Starts a run (optionally writing one sample in the start cycle) and checks every cycle of it.
    task automatic run(input logic [DW-1:0] lr, input bit noise, input int abort_c,
                       input bit do_ld, input int ld_a);
        int e_end = end_epoch();
        int last = e_end * (2 * NS + 2) + 1;
        if (do_ld) begin
            load_valid = 1'b1; load_addr = 2'(ld_a);
            load_values = {DW'($urandom), DW'($urandom)}; load_expected = DW'($urandom);
            m_vals[ld_a] = load_values; m_exp[ld_a] = load_expected;
        end
        start = 1'b1; lr_in = lr;
        @(posedge clk); #1;
        start = 1'b0; load_valid = 1'b0; lr_in = DW'($urandom);
        for (int c = 0; c <= last; c++) begin
            pred0 = pred_for(c, 1, e_end);
            pred1 = pred_for(c, 2, e_end);
            if (noise && c < e_end * (2 * NS + 1)) begin
                start = 1'(($urandom_range(1)));
                load_valid = 1'(($urandom_range(1)));
                load_addr = 2'($urandom_range(NS-1));
                load_values = {DW'($urandom), DW'($urandom)};
                load_expected = DW'($urandom);
            end else begin
                start = 1'b0; load_valid = 1'b0;
            end
            check_unit(0, c, 1, e_end, lr, values0, expected0, training0, busy0, done0, conv0, epoch0, correct0, lr0);
            check_unit(1, c, 2, e_end, lr, values1, expected1, training1, busy1, done1, conv1, epoch1, correct1, lr1);
            if (c == abort_c) begin
                start = 1'b0; load_valid = 1'b0;
                #2 rst = 1'b0;
                #1 check_zero("async abort");
                repeat (3) @(posedge clk);
                #1 check_zero("held abort");
                rst = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < NS; k++) begin m_vals[k] = '0; m_exp[k] = '0; end
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; load_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin m_vals[k] = '0; m_exp[k] = '0; end
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("after release");

        load_and();
        make_plan($urandom_range(1, EP - 2));
        run(ONE, 1'b0, -1, 1'b0, 0);

        load_xor();
        make_plan(EP);
        run(ONE, 1'b0, -1, 1'b0, 0);

        for (int k = 0; k < NS; k++) do_load(k, {DW'($urandom), DW'($urandom)}, DW'($urandom));
        make_plan($urandom_range(0, EP));
        run(DW'($urandom), 1'b1, -1, 1'b1, 3);

        make_plan($urandom_range(0, EP));
        run(DW'($urandom), 1'b0, -1, 1'b1, 0);

        load_and();
        make_plan(EP);
        run(ONE, 1'b0, 2 * (2 * NS + 1) + NS + 1, 1'b0, 0);

        make_plan(0);
        run(ONE, 1'b0, -1, 1'b0, 0);

        load_and();
        make_plan($urandom_range(0, EP));
        run(ONE, 1'b0, -1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
